// File: rtl/obc_bitplane_sequencer_if.sv
// Bundle between the bit-plane sequencer, its sample producer, the OBC ROM stage and the result consumer.
// No storage, so no latency.
// Carries both valid/ready pairs and the combinational ROM round trip (bit_x/m out, romout back).
interface obc_bitplane_sequencer_if #(
    parameter int DW   = 16,
    parameter int ACCW = 32 + DW
);
    logic              in_valid;
    logic              in_ready;
    logic [16*DW-1:0]  din;
    logic [15:0]       bit_x;
    logic              m;
    logic [31:0]       romout;
    logic              out_valid;
    logic              out_ready;
    logic [ACCW-1:0]   dout;

    // Sequencer side
    modport slave (
        input  in_valid, din, romout, out_ready,
        output in_ready, bit_x, m, out_valid, dout
    );

    // Producer / ROM / consumer side
    modport master (
        output in_valid, din, romout, out_ready,
        input  in_ready, bit_x, m, out_valid, dout
    );
endinterface

// File: rtl/obc_bitplane_sequencer.sv
// Walks 16 captured samples bit-plane by bit-plane (LSB first) through an OBC ROM and shift-accumulates the partial sums.
// Latency: out_valid rises DW cycles after the load edge; one transform every DW+2 cycles.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module obc_bitplane_sequencer #(
    parameter int DW   = 16,
    parameter int ACCW = 32 + DW
) (
    input  logic                    clk,
    input  logic                    rst,
    obc_bitplane_sequencer_if.slave bus
);
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [BW-1:0]     b_q;
    logic [ACCW-1:0]   acc_q;
    logic [16*DW-1:0]  smp_q;
    logic              load;
    logic              run;
    logic              last;
    logic [ACCW-1:0]   rom_ext;

    assign last    = (b_q == BW'(DW - 1));
    // ROM partial sum is signed; widen before shifting so high planes keep their sign.
    assign rom_ext = ACCW'($signed(bus.romout));
    assign bus.dout = acc_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        run           = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                run = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Current bit-plane to the ROM; quiet outside RUN
    always_comb begin
        bus.bit_x = '0;
        bus.m     = 1'b0;
        if (run) begin
            for (int k = 0; k < 16; k++) begin
                bus.bit_x[k] = smp_q[k*DW + int'(b_q)];
            end
            bus.m = last;
        end
    end

    // Sample capture, plane index and shift-accumulate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q <= '0;
            acc_q <= '0;
            b_q   <= '0;
        end else if (load) begin
            smp_q <= bus.din;
            acc_q <= '0;
            b_q   <= '0;
        end else if (run) begin
            acc_q <= acc_q + (rom_ext << b_q);
            if (!last) begin
                b_q <= b_q + 1'b1;
            end
        end
    end
endmodule

// File: doc/obc_bitplane_sequencer.md
OBC_BITPLANE_SEQUENCER -- requirements
Module: obc_bitplane_sequencer

Interface
REQ-001 Parameter DW, default 16: bit width of each input sample and number of bit-planes per transform.
REQ-002 Parameter ACCW, default 32+DW: width of the result accumulator and of dout.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  asserts that din holds a new set of 16 samples.
REQ-006 in_ready  output  1  block can accept a load.
REQ-007 din  input  16*DW  samples; sample k (k=0..15) is at bits [k*DW +: DW], two's complement.
REQ-008 bit_x  output  16  current bit-plane to the OBC ROM stage; bit_x[k] drives ROM address input x0k.
REQ-009 m  output  1  MSB-plane flag to the ROM stage; high only while the plane DW-1 is driven.
REQ-010 romout  input  32  signed partial sum returned combinationally by the ROM stage for the current bit_x/m.
REQ-011 out_valid  output  1  dout holds a finished result.
REQ-012 out_ready  input  1  consumer accepts dout.
REQ-013 dout  output  ACCW  signed accumulated transform output.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-016 A load SHALL occur on an edge with IDLE and in_valid=1: capture din, clear the accumulator, set plane index b=0, go to RUN.
REQ-017 In RUN, bit_x[k] SHALL equal bit b of captured sample k, and m SHALL be 1 iff b==DW-1.
REQ-018 On each RUN edge, acc SHALL become acc + (sign-extended romout << b), computed at ACCW bits with wrap-around.
REQ-019 On the edge where b==DW-1 is accumulated, the FSM SHALL go to DONE; otherwise b SHALL increment.
REQ-020 Planes SHALL be issued LSB first, one per cycle, with no gaps.
REQ-021 out_valid SHALL be 1 exactly in DONE; dout SHALL equal acc and stay stable while out_valid=1 and out_ready=0.
REQ-022 On an edge with DONE and out_ready=1, the FSM SHALL go to IDLE.
REQ-023 Latency: out_valid SHALL rise DW cycles after the load edge.
REQ-024 Throughput with out_ready held at 1 SHALL be one transform per DW+2 cycles.
REQ-025 In IDLE and DONE, bit_x SHALL be 0 and m SHALL be 0.
REQ-026 in_valid outside IDLE SHALL be ignored; din changes after the load edge SHALL have no effect.
REQ-027 out_ready outside DONE SHALL be ignored.

Reset
REQ-028 While rst=1 (asynchronous), the FSM SHALL be IDLE and b=0, acc=0, captured samples=0.
REQ-029 While rst=1, outputs SHALL be in_ready=1, out_valid=0, bit_x=0, m=0, dout=0.
REQ-030 Reset asserted mid-RUN or in DONE SHALL discard the transform in progress with no out_valid pulse.
REQ-031 The first load after reset release SHALL be accepted on the first edge with in_valid=1.

Verification
REQ-032 Bench SHALL cover: sample0=0x0001, others 0 -> bit_x=0x0001 in RUN cycle 0 and 0x0000 in cycles 1..15; m=1 only in cycle 15.
REQ-033 Bench SHALL cover: bench ROM model drives romout=1 constant -> dout=65535 (0x00_0000_FFFF at DW=16), out_valid 16 cycles after the load edge.
REQ-034 Bench SHALL cover: romout=0xFFFFFFFF constant -> dout=-65535 (0xFFFF_FFFF_0001 at 48 bits).
REQ-035 Bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> dout and out_valid stable, in_ready=0, with in_valid=1 pulses ignored.
REQ-036 Bench SHALL cover: rst pulsed during plane 7 -> immediately in_ready=1, out_valid=0, bit_x=0; the next load produces a correct, uncorrupted result.
REQ-037 Bench SHALL cover: back-to-back loads with out_ready=1 and in_valid=1 held -> one out_valid pulse every 18 cycles, each dout matching the reference ROM model.
